// File: rtl/uk101_video_timing.sv
// uk101_video_timing: raster timing and character-fetch engine for the UK101
// display (64x32 characters, 8x8 glyph cell, 50 Hz PAL-style raster).
//
// Ports
//   clk          in   system clock
//   n_reset      in   asynchronous active-low reset
//   ce_pix       out  one-clk pulse every PIX_DIV clks
//   vram_addr    out  {row[4:0], col[5:0]} to synchronous video RAM
//   vram_data    in   character code, one clk after vram_addr is sampled
//   chrom_addr   out  {code[7:0], glyph_line[2:0]} to synchronous character ROM
//   chrom_data   in   glyph row, bit 7 = leftmost pixel, one clk after chrom_addr is sampled
//   pixel        out  mono video, 1 = lit
//   hsync        out  horizontal sync, active-high
//   vsync        out  vertical sync, active-high
//   hblank       out  high outside the active pixels of a line
//   vblank       out  high outside the active lines of a frame
//   de           out  ~(hblank | vblank)
//   frame_start  out  one-clk pulse coincident with the ce_pix tick at h=0, v=0
//
// pixel/hsync/vsync/hblank/vblank/de describe the previous ce_pix tick's raster
// position and are mutually aligned. PIX_DIV must lie in 3..15 so that a
// character fetch always completes well inside one 8-pixel cell.
module uk101_video_timing #(
    parameter int unsigned PIX_DIV  = 4,
    parameter int unsigned H_ACTIVE = 512,
    parameter int unsigned H_FP     = 96,
    parameter int unsigned H_SYNC   = 64,
    parameter int unsigned H_BP     = 128,
    parameter int unsigned V_ACTIVE = 256,
    parameter int unsigned V_FP     = 24,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 29
) (
    input  logic        clk,
    input  logic        n_reset,
    output logic        ce_pix,
    output logic [10:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic [10:0] chrom_addr,
    input  logic [7:0]  chrom_data,
    output logic        pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        de,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W    = $clog2(PIX_DIV);
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CODE  = 3'd2,
        S_GLYPH = 3'd3,
        S_LOAD  = 3'd4
    } fetch_state_e;

    // Divider and raster counters
    logic [DIV_W-1:0] div_q;
    logic             ce_q;
    logic             fs_q;
    logic [H_W-1:0]   h_q;
    logic [V_W-1:0]   v_q;

    // Raster decode of the current tick
    logic             h_last_c;
    logic             v_last_c;
    logic             hblank_c;
    logic             vblank_c;
    logic             hsync_c;
    logic             vsync_c;

    // Fetch target
    logic             cell_tick_c;
    logic             fetch_same_c;
    logic             fetch_next_c;
    logic             trigger_c;
    logic [V_W-1:0]   v_next_c;
    logic [V_W-1:0]   tv_c;
    logic [5:0]       col_c;
    logic [4:0]       row_c;
    logic [2:0]       gline_c;

    // Fetch engine and pixel path
    fetch_state_e     state_q;
    logic [10:0]      vram_addr_q;
    logic [10:0]      chrom_addr_q;
    logic [2:0]       line_q;
    logic [7:0]       hold_q;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             load_c;

    // Registered outputs
    logic             pixel_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             hblank_q;
    logic             vblank_q;
    logic             de_q;

    // Pixel clock enable: ce_q is high while div_q == PIX_DIV-1
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div_q <= '0;
            ce_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= (div_q == DIV_W'(PIX_DIV - 1)) ? '0 : div_q + DIV_W'(1);
            ce_q  <= (div_q == DIV_W'(PIX_DIV - 2));
            // h_q/v_q already hold the upcoming tick's position here
            fs_q  <= (div_q == DIV_W'(PIX_DIV - 2)) && (h_q == '0) && (v_q == '0);
        end
    end

    // Raster counters, advanced once per pixel tick
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (ce_q) begin
            h_q <= h_last_c ? '0 : h_q + H_W'(1);
            if (h_last_c) begin
                v_q <= v_last_c ? '0 : v_q + V_W'(1);
            end
        end
    end

    // Timing decode and next-cell fetch target
    always_comb begin
        h_last_c     = (h_q == H_W'(H_TOTAL - 1));
        v_last_c     = (v_q == V_W'(V_TOTAL - 1));
        hblank_c     = (h_q >= H_W'(H_ACTIVE));
        vblank_c     = (v_q >= V_W'(V_ACTIVE));
        hsync_c      = (h_q >= H_W'(HS_START)) && (h_q < H_W'(HS_END));
        vsync_c      = (v_q >= V_W'(VS_START)) && (v_q < V_W'(VS_END));

        cell_tick_c  = ce_q && (h_q[2:0] == 3'd0);
        fetch_same_c = (h_q < H_W'(H_ACTIVE - 8));
        fetch_next_c = (h_q == H_W'(H_TOTAL - 8));
        trigger_c    = cell_tick_c && (fetch_same_c || fetch_next_c);

        // Last cell of the line prefetches column 0 of the following line
        v_next_c     = v_last_c ? '0 : v_q + V_W'(1);
        tv_c         = fetch_next_c ? v_next_c : v_q;
        col_c        = fetch_next_c ? 6'd0 : 6'(h_q >> 3) + 6'd1;
        row_c        = 5'(tv_c >> 3);
        gline_c      = 3'(tv_c);

        load_c       = cell_tick_c && !hblank_c;
        shift_d      = load_c ? hold_q : (shift_q << 1);
    end

    // Character fetch: RAM and ROM each return data one clk after their address
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= S_IDLE;
            vram_addr_q  <= '0;
            chrom_addr_q <= '0;
            line_q       <= '0;
            hold_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger_c) begin
                        vram_addr_q <= {row_c, col_c};
                        line_q      <= gline_c;
                        state_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state_q <= S_CODE;
                end
                S_CODE: begin
                    chrom_addr_q <= {vram_data, line_q};
                    state_q      <= S_GLYPH;
                end
                S_GLYPH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    hold_q  <= chrom_data;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Shifter and output pipeline; pixel uses the shifter value for this tick
    // so that glyph bit 7 lines up with the first column of its cell.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shift_q  <= '0;
            pixel_q  <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            de_q     <= 1'b0;
        end else if (ce_q) begin
            shift_q  <= shift_d;
            pixel_q  <= shift_d[7] & ~hblank_c & ~vblank_c;
            hsync_q  <= hsync_c;
            vsync_q  <= vsync_c;
            hblank_q <= hblank_c;
            vblank_q <= vblank_c;
            de_q     <= ~(hblank_c | vblank_c);
        end
    end

    assign ce_pix      = ce_q;
    assign frame_start = fs_q;
    assign vram_addr   = vram_addr_q;
    assign chrom_addr  = chrom_addr_q;
    assign pixel       = pixel_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;

endmodule

// File: tb/tb_uk101_video_timing.sv
// Bench for uk101_video_timing on a reduced raster (96x24 total, 64x16 active)
// so several frames fit in a short run. A reference model derives every
// tick's expected outputs from the tick index and the memory images.
module tb_uk101_video_timing;

    localparam int PIX_DIV  = 4;
    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 8;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 16;
    localparam int V_ACTIVE = 16;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 3;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int RST_TICK = 10 * H_TOTAL + 30;

    // {frame_start, pixel, hsync, vsync, hblank, vblank, de}
    typedef logic [6:0] vec_t;
    typedef struct {
        string  name;
        longint got;
        longint req;
    } chk_t;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        ce_pix;
    logic [10:0] vram_addr;
    logic [10:0] chrom_addr;
    logic [7:0]  vram_data;
    logic [7:0]  chrom_data;
    logic        pixel, hsync, vsync, hblank, vblank, de, frame_start;

    logic [7:0]  vram [2048];
    logic [7:0]  rom  [2048];

    vec_t        exp_q [$];
    int          tick_q [$];
    chk_t        chk_q [$];

    int          compared = 0;
    int          mismatched = 0;
    bit          mon_en = 1'b0;
    string       phase = "init";

    // Monitor-owned state
    int          cyc = 0;
    int          last_ce = 0;
    bit          first_ce = 1'b1;
    bit          hs_prev = 1'b0;
    bit          vs_prev = 1'b0;
    int          hs_rise = -1;
    int          vs_rise = -1;
    int          hs_period = 0;
    int          hs_high = 0;
    int          vs_period = 0;
    int          vs_high = 0;
    int          de_ticks = 0;
    int          fs_seen = 0;
    vec_t        mon_got;
    vec_t        mon_exp;
    int          mon_t;
    chk_t        mon_chk;

    uk101_video_timing #(
        .PIX_DIV  (PIX_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .ce_pix      (ce_pix),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data),
        .chrom_addr  (chrom_addr),
        .chrom_data  (chrom_data),
        .pixel       (pixel),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .de          (de),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one clk of read latency
    always @(posedge clk) begin
        vram_data  <= vram[vram_addr];
        chrom_data <= rom[chrom_addr];
    end

    // Expected outputs seen on the ce_pix of tick t
    function automatic vec_t model(int t);
        vec_t       r;
        int         pt, ph, pv, a, ra;
        logic [7:0] code, glyph;
        r = '0;
        r[6] = ((t % FRAME) == 0);
        if (t > 0) begin
            pt = t - 1;
            ph = pt % H_TOTAL;
            pv = (pt / H_TOTAL) % V_TOTAL;
            r[2] = (ph >= H_ACTIVE);
            r[1] = (pv >= V_ACTIVE);
            r[0] = !(r[2] || r[1]);
            r[4] = (ph >= H_ACTIVE + H_FP) && (ph < H_ACTIVE + H_FP + H_SYNC);
            r[3] = (pv >= V_ACTIVE + V_FP) && (pv < V_ACTIVE + V_FP + V_SYNC);
            if (r[0] && !(pt < H_TOTAL && ph < 8)) begin
                a     = ((pv / 8) % 32) * 64 + ph / 8;
                code  = vram[a];
                ra    = int'(code) * 8 + pv % 8;
                glyph = rom[ra];
                r[5]  = glyph[7 - ph % 8];
            end
        end
        return r;
    endfunction

    function automatic longint all_outputs();
        return 64'({ce_pix, vram_addr, chrom_addr, pixel, hsync, vsync,
                    hblank, vblank, de, frame_start});
    endfunction

    // Monitor: owns all comparisons and counters
    always @(negedge clk) begin
        if (chk_q.size() != 0) begin
            mon_chk = chk_q.pop_front();
            compared++;
            if (mon_chk.got != mon_chk.req) begin
                mismatched++;
                $display("FAIL %s: got %0d required %0d", mon_chk.name, mon_chk.got, mon_chk.req);
            end
        end
        if (!n_reset) begin
            cyc      = 0;
            first_ce = 1'b1;
            hs_prev  = 1'b0;
            vs_prev  = 1'b0;
            hs_rise  = -1;
            vs_rise  = -1;
            de_ticks = 0;
            fs_seen  = 0;
        end else begin
            cyc++;
            if (hsync && !hs_prev) begin
                if (hs_rise >= 0) hs_period = cyc - hs_rise;
                hs_rise = cyc;
            end
            if (!hsync && hs_prev && hs_rise >= 0) hs_high = cyc - hs_rise;
            if (vsync && !vs_prev) begin
                if (vs_rise >= 0) vs_period = cyc - vs_rise;
                vs_rise = cyc;
            end
            if (!vsync && vs_prev && vs_rise >= 0) vs_high = cyc - vs_rise;
            hs_prev = hsync;
            vs_prev = vsync;

            if (mon_en && ce_pix) begin
                compared++;
                if (first_ce) begin
                    if (cyc != PIX_DIV) begin
                        mismatched++;
                        $display("FAIL %s ce_first: got clk %0d required clk %0d", phase, cyc, PIX_DIV);
                    end
                end else if (cyc - last_ce != PIX_DIV) begin
                    mismatched++;
                    $display("FAIL %s ce_period: got %0d required %0d", phase, cyc - last_ce, PIX_DIV);
                end
                first_ce = 1'b0;
                last_ce  = cyc;

                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL %s extra_tick: got a ce_pix at clk %0d required none", phase, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_t   = tick_q.pop_front();
                    mon_got = {frame_start, pixel, hsync, vsync, hblank, vblank, de};
                    if (mon_got !== mon_exp) begin
                        mismatched++;
                        $display("FAIL %s tick %0d (fs,pix,hs,vs,hb,vb,de): got %b required %b",
                                 phase, mon_t, mon_got, mon_exp);
                    end
                    if (mon_t >= 1 && mon_t <= FRAME && de) de_ticks++;
                    if (mon_t < FRAME && frame_start) fs_seen++;
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint req);
        chk_t c;
        c.name = name;
        c.got  = got;
        c.req  = req;
        chk_q.push_back(c);
    endtask

    task automatic push_ticks(input int from, input int to);
        for (int t = from; t <= to; t++) begin
            exp_q.push_back(model(t));
            tick_q.push_back(t);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        n_reset = 1'b1;
    endtask

    task automatic drain(input int ticks);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < (ticks + 4) * PIX_DIV + 20) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk({phase, "_drain_timeout"}, longint'(exp_q.size()), 0);
        mon_en = 1'b0;
    endtask

    task automatic load_text();
        for (int i = 0; i < 2048; i++) begin
            vram[i] = 8'h20;
            rom[i]  = 8'h00;
        end
        vram[11'h000] = 8'h41;
        vram[11'h001] = 8'h41;
        vram[11'h047] = 8'hFF;
        rom[8'h41 * 8 + 0] = 8'h18;
        rom[8'hFF * 8 + 7] = 8'hFF;
        rom[8'h20 * 8 + 2] = 8'h81;
    endtask

    task automatic load_solid();
        for (int i = 0; i < 2048; i++) begin
            vram[i] = 8'($urandom_range(0, 255));
            rom[i]  = 8'hFF;
        end
    endtask

    initial begin
        load_text();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", all_outputs(), 0);

        // Two frames of text: glyph timing, sync periods, frame_start cadence
        phase = "text";
        push_ticks(0, 2 * FRAME);
        mon_en = 1'b1;
        release_reset();
        drain(2 * FRAME + 1);
        @(negedge clk);
        chk("hsync_period_clks", hs_period, H_TOTAL * PIX_DIV);
        chk("hsync_high_clks", hs_high, H_SYNC * PIX_DIV);
        chk("vsync_period_clks", vs_period, FRAME * PIX_DIV);
        chk("vsync_high_clks", vs_high, V_SYNC * H_TOTAL * PIX_DIV);
        chk("de_ticks_per_frame", de_ticks, H_ACTIVE * V_ACTIVE);
        chk("frame_start_per_frame", fs_seen, 1);

        // Every glyph lit: blanking must mask everything outside the active area
        #2;
        n_reset = 1'b0;
        repeat (4) @(posedge clk);
        load_solid();
        phase = "solid";
        push_ticks(0, FRAME);
        mon_en = 1'b1;
        release_reset();
        drain(FRAME + 1);

        // Reset asserted mid-frame at v=10, h=30
        #2;
        n_reset = 1'b0;
        repeat (4) @(posedge clk);
        load_text();
        phase = "pre_reset";
        push_ticks(0, RST_TICK);
        mon_en = 1'b1;
        release_reset();
        drain(RST_TICK + 1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_outputs(), 0);
        repeat (7) @(posedge clk);
        phase = "post_reset";
        push_ticks(0, FRAME);
        mon_en = 1'b1;
        release_reset();
        drain(FRAME + 1);

        for (int i = 0; i < 50 && chk_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
